hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core (F/D/X/M/W).
- Tracks destination registers of in-flight instructions in X, M and W.
- Generates X-stage forwarding selects, load-use stalls, and F/D flushes for taken BEQ (resolved in X) and JUMP (decoded in D).
- Sits beside control; consumes its D-stage decode outputs and BeqValid_X.

---
 rtl/mips_pkg.sv | 33 +++
 rtl/hazard_match.sv | 25 ++
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared types for the MIPS pipeline hazard controller
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int HZ_REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } t_fwd_sel;

  typedef enum logic [0:0] {
    HZ_RUN   = 1'b0,
    HZ_STALL = 1'b1
  } t_hz_state;

  typedef struct packed {
    logic                 valid;
    logic [HZ_REG_AW-1:0] dst;
    logic                 reg_write;
    logic                 mem_read;
  } t_hz_entry;

  localparam t_hz_entry HZ_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/hazard_match.sv
// ============================================================================
// hazard_match : RAW compare of one in-flight producer against one source reg
// Revision     : 1.0
// ============================================================================
`default_nettype none

module hazard_match
  import mips_pkg::*;
(
  input  t_hz_entry            entry,
  input  logic [HZ_REG_AW-1:0] src,
  input  logic                 uses,
  output logic                 match
);

  // Load-ness only matters to the caller, not to the compare itself
  logic unused_mem_read;
  assign unused_mem_read = entry.mem_read;

  assign match = uses & entry.valid & entry.reg_write &
                 (entry.dst != '0) & (entry.dst == src);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : forwarding selects, RAW/load-use stalls and branch/jump flushes
//               for the 5-stage core. Build macro: FWD_EN (forwarding enabled).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int REG_AW           = HZ_REG_AW,
  parameter int NUM_PIPE_ENTRIES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs_D,
  input  logic [REG_AW-1:0] rt_D,
  input  logic              uses_rs_D,
  input  logic              uses_rt_D,
  input  logic [REG_AW-1:0] dst_D,
  input  logic              RegWrite_D,
  input  logic              MemRead_D,
  input  logic              Jump_D,
  input  logic              BeqValid_X,
  output logic              Stall_F,
  output logic              Stall_D,
  output logic              Flush_F,
  output logic              Flush_D,
  output logic [1:0]        fwd_a_X,
  output logic [1:0]        fwd_b_X
);

  t_hz_entry         x_q, m_q, w_q, d_entry;
  logic [REG_AW-1:0] rs_x, rt_x;
  logic              uses_rs_x, uses_rt_x;
  t_hz_state         state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;

  logic rs_d_x, rt_d_x, rs_d_m, rt_d_m;
  logic rs_x_m, rt_x_m, rs_x_w, rt_x_w;
  logic stall, flush_f, flush_d;

  assign d_entry = '{valid: 1'b1, dst: dst_D, reg_write: RegWrite_D, mem_read: MemRead_D};

  hazard_match u_rs_d_x (.entry(x_q), .src(rs_D), .uses(uses_rs_D), .match(rs_d_x));
  hazard_match u_rt_d_x (.entry(x_q), .src(rt_D), .uses(uses_rt_D), .match(rt_d_x));
  hazard_match u_rs_d_m (.entry(m_q), .src(rs_D), .uses(uses_rs_D), .match(rs_d_m));
  hazard_match u_rt_d_m (.entry(m_q), .src(rt_D), .uses(uses_rt_D), .match(rt_d_m));
  hazard_match u_rs_x_m (.entry(m_q), .src(rs_x), .uses(uses_rs_x), .match(rs_x_m));
  hazard_match u_rt_x_m (.entry(m_q), .src(rt_x), .uses(uses_rt_x), .match(rt_x_m));
  hazard_match u_rs_x_w (.entry(w_q), .src(rs_x), .uses(uses_rs_x), .match(rs_x_w));
  hazard_match u_rt_x_w (.entry(w_q), .src(rt_x), .uses(uses_rt_x), .match(rt_x_w));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    flush_f = 1'b0;
    flush_d = 1'b0;
    case (state_q)
      HZ_RUN: begin
`ifdef FWD_EN
        if ((rs_d_x | rt_d_x) & x_q.mem_read) stall = 1'b1;
`else
        // The youngest producer sets the stall length: X needs two cycles, M one
        if (rs_d_x | rt_d_x) begin
          stall   = 1'b1;
          state_d = HZ_STALL;
          cnt_d   = 2'd1;
        end else if (rs_d_m | rt_d_m) begin
          stall = 1'b1;
        end
`endif
      end
      HZ_STALL: begin
        stall = 1'b1;
        cnt_d = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
        if (cnt_d == 2'd0) state_d = HZ_RUN;
      end
      default: begin
        state_d = HZ_RUN;
        cnt_d   = 2'd0;
      end
    endcase

    // A taken branch squashes both younger instructions and cancels any stall
    if (BeqValid_X) begin
      stall   = 1'b0;
      flush_f = 1'b1;
      flush_d = 1'b1;
      state_d = HZ_RUN;
      cnt_d   = 2'd0;
    end else if (stall) begin
      flush_d = 1'b1;
    end else if (Jump_D) begin
      flush_f = 1'b1;
    end
  end

  assign Stall_F = stall & ~rst;
  assign Stall_D = stall & ~rst;
  assign Flush_F = flush_f & ~rst;
  assign Flush_D = flush_d & ~rst;

`ifdef FWD_EN
  t_fwd_sel fwd_a_sel, fwd_b_sel;
  assign fwd_a_sel = rs_x_m ? FWD_M : (rs_x_w ? FWD_W : FWD_RF);
  assign fwd_b_sel = rt_x_m ? FWD_M : (rt_x_w ? FWD_W : FWD_RF);
  assign fwd_a_X   = rst ? FWD_RF : fwd_a_sel;
  assign fwd_b_X   = rst ? FWD_RF : fwd_b_sel;

  logic unused_m_match;
  assign unused_m_match = rs_d_m ^ rt_d_m;
`else
  assign fwd_a_X = FWD_RF;
  assign fwd_b_X = FWD_RF;

  logic unused_fwd_match;
  assign unused_fwd_match = rs_x_m ^ rt_x_m ^ rs_x_w ^ rt_x_w;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HZ_RUN;
      cnt_q     <= 2'd0;
      x_q       <= HZ_BUBBLE;
      m_q       <= HZ_BUBBLE;
      w_q       <= HZ_BUBBLE;
      rs_x      <= '0;
      rt_x      <= '0;
      uses_rs_x <= 1'b0;
      uses_rt_x <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= m_q;
      m_q     <= x_q;
      if (flush_d) begin
        x_q       <= HZ_BUBBLE;
        uses_rs_x <= 1'b0;
        uses_rt_x <= 1'b0;
      end else begin
        x_q       <= d_entry;
        rs_x      <= rs_D;
        rt_x      <= rt_D;
        uses_rs_x <= uses_rs_D;
        uses_rt_x <= uses_rt_D;
      end
    end
  end

  // Remaining stall cycles can never reach the depth of the tracked pipe
  always @(posedge clk) begin
    if (!rst) assert (int'(cnt_q) < NUM_PIPE_ENTRIES);
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : directed-vector bench for hazard_ctrl (both FWD_EN builds)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] rs_D, rt_D, dst_D;
  logic       uses_rs_D, uses_rt_D, RegWrite_D, MemRead_D, Jump_D, BeqValid_X;
  logic       Stall_F, Stall_D, Flush_F, Flush_D;
  logic [1:0] fwd_a_X, fwd_b_X;

  int n_checks = 0;
  int n_errors = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .rs_D(rs_D), .rt_D(rt_D), .uses_rs_D(uses_rs_D), .uses_rt_D(uses_rt_D),
    .dst_D(dst_D), .RegWrite_D(RegWrite_D), .MemRead_D(MemRead_D),
    .Jump_D(Jump_D), .BeqValid_X(BeqValid_X),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_F(Flush_F), .Flush_D(Flush_D),
    .fwd_a_X(fwd_a_X), .fwd_b_X(fwd_b_X)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // outs = {Stall_F, Stall_D, Flush_F, Flush_D, fwd_a_X, fwd_b_X}
  logic [7:0] outs;
  assign outs = {Stall_F, Stall_D, Flush_F, Flush_D, fwd_a_X, fwd_b_X};

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drv(input int rs, input int rt, input bit urs, input bit urt,
                     input int dst, input bit rw, input bit mr,
                     input bit j, input bit beq);
    rs_D       = rs[4:0];
    rt_D       = rt[4:0];
    uses_rs_D  = urs;
    uses_rt_D  = urt;
    dst_D      = dst[4:0];
    RegWrite_D = rw;
    MemRead_D  = mr;
    Jump_D     = j;
    BeqValid_X = beq;
  endtask

  // check mid-cycle, then advance to just after the next rising edge
  task automatic cyc(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    // hazard-provoking inputs while in reset: outputs must still be zero
    drv(3, 3, 1, 1, 3, 1, 1, 1, 1);
    cyc("rst_outs", 8'h00);
    rst = 1'b0;

`ifdef FWD_EN
    drv(1, 2, 1, 1, 3, 1, 0, 0, 0);   cyc("add3_issue", 8'h00);
    drv(3, 5, 1, 1, 4, 1, 0, 0, 0);   cyc("sub_dep_no_stall", 8'h00);
    nop();                            cyc("fwd_a_from_m", 8'h08);
    drv(3, 4, 1, 1, 7, 1, 0, 0, 0);   cyc("sub7_issue", 8'h00);
    nop();                            cyc("fwd_b_from_w", 8'h01);
    drv(1, 0, 1, 0, 2, 1, 1, 0, 0);   cyc("lw_issue", 8'h00);
    drv(2, 2, 1, 1, 4, 1, 0, 0, 0);   cyc("load_use_stall", 8'hD0);
    drv(2, 2, 1, 1, 4, 1, 0, 0, 0);   cyc("load_use_release", 8'h00);
    nop();                            cyc("load_fwd_w_ab", 8'h05);
    drv(1, 1, 1, 1, 5, 1, 0, 0, 0);   cyc("add5_issue", 8'h00);
    drv(1, 2, 1, 1, 5, 1, 0, 0, 0);   cyc("sub5_issue", 8'h00);
    drv(5, 0, 1, 0, 6, 1, 0, 0, 0);   cyc("or_dep_no_stall", 8'h00);
    nop();                            cyc("fwd_m_priority", 8'h08);
    drv(1, 2, 1, 1, 0, 1, 0, 0, 0);   cyc("add0_issue", 8'h00);
    drv(0, 0, 1, 1, 4, 1, 0, 0, 0);   cyc("zero_reg_no_stall", 8'h00);
    nop();                            cyc("zero_reg_no_fwd", 8'h00);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0);   cyc("jump_flush", 8'h20);
    drv(1, 0, 1, 0, 2, 1, 1, 0, 0);   cyc("lw2_issue", 8'h00);
    drv(2, 2, 1, 1, 4, 1, 0, 1, 1);   cyc("beq_over_stall", 8'h30);
    drv(1, 0, 1, 0, 2, 1, 1, 0, 0);   cyc("lw3_issue", 8'h00);
    drv(2, 2, 1, 1, 4, 1, 0, 0, 0);   cyc("stall_before_rst", 8'hD0);
    rst = 1'b1;                       cyc("rst_mid_stall", 8'h00);
    rst = 1'b0;                       cyc("post_rst_no_stall", 8'h00);
`else
    drv(1, 2, 1, 1, 3, 1, 0, 0, 0);   cyc("add3_issue", 8'h00);
    drv(3, 5, 1, 1, 4, 1, 0, 0, 0);   cyc("raw_x_stall1", 8'hD0);
    drv(3, 5, 1, 1, 4, 1, 0, 1, 0);   cyc("raw_x_stall2_jump_ignored", 8'hD0);
    drv(3, 5, 1, 1, 4, 1, 0, 0, 0);   cyc("raw_resume", 8'h00);
    nop();                            cyc("fwd_tied_off", 8'h00);
    drv(4, 0, 1, 0, 6, 1, 0, 0, 0);   cyc("raw_m_stall", 8'hD0);
    drv(4, 0, 1, 0, 6, 1, 0, 0, 0);   cyc("w_no_stall", 8'h00);
    drv(1, 2, 1, 1, 0, 1, 0, 0, 0);   cyc("add0_issue", 8'h00);
    drv(0, 0, 1, 1, 4, 1, 0, 0, 0);   cyc("zero_reg_no_stall", 8'h00);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0);   cyc("jump_flush", 8'h20);
    drv(1, 0, 1, 0, 2, 1, 1, 0, 0);   cyc("lw_issue", 8'h00);
    drv(2, 2, 1, 1, 4, 1, 0, 1, 1);   cyc("beq_over_stall", 8'h30);
    drv(2, 2, 1, 1, 4, 1, 0, 0, 0);   cyc("load_in_m_stall", 8'hD0);
    drv(2, 2, 1, 1, 4, 1, 0, 0, 0);   cyc("load_in_w_release", 8'h00);
    drv(1, 2, 1, 1, 3, 1, 0, 0, 0);   cyc("add3_again", 8'h00);
    drv(3, 5, 1, 1, 4, 1, 0, 0, 0);   cyc("stall_before_rst", 8'hD0);
    rst = 1'b1;                       cyc("rst_mid_stall", 8'h00);
    rst = 1'b0;                       cyc("post_rst_no_stall", 8'h00);
    drv(1, 2, 1, 1, 3, 1, 0, 0, 0);   cyc("post_rst_add3", 8'h00);
    drv(3, 5, 1, 1, 4, 1, 0, 0, 0);   cyc("post_rst_stall1", 8'hD0);
    drv(3, 5, 1, 1, 4, 1, 0, 0, 0);   cyc("post_rst_stall2", 8'hD0);
    drv(3, 5, 1, 1, 4, 1, 0, 0, 0);   cyc("post_rst_resume", 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
